// File: rtl/decryption_dispatcher_if.sv
// Bus bundle between the decryption dispatcher and its neighbours.
// Purpose: groups the upstream character stream, the shared engine bus and
//          the decrypted output stream into one interface.
// Modports:
//   slave  - the dispatcher side (consumes upstream/engine inputs, drives outputs)
//   master - the environment side (upstream source plus the three engines)
// Signals:
//   data_i/valid_i/sel_i/key_i          upstream character, valid, engine select, key
//   busy_o                              dispatcher busy, upstream holds valid_i low
//   eng_data_o/eng_valid_o/eng_key_o    shared character bus, one-hot valid, latched key
//   eng_busy_i/eng_data_i/eng_valid_i   per-engine busy, packed outputs, output valids
//   data_o/valid_o                      decrypted character stream
//   err_o                               one-cycle protocol error pulse
interface decryption_dispatcher_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 16
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [1:0]           sel_i;
  logic [KEY_WIDTH-1:0] key_i;
  logic                 busy_o;
  logic [D_WIDTH-1:0]   eng_data_o;
  logic [2:0]           eng_valid_o;
  logic [KEY_WIDTH-1:0] eng_key_o;
  logic [2:0]           eng_busy_i;
  logic [3*D_WIDTH-1:0] eng_data_i;
  logic [2:0]           eng_valid_i;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 err_o;

  modport slave (
    input  data_i, valid_i, sel_i, key_i, eng_busy_i, eng_data_i, eng_valid_i,
    output busy_o, eng_data_o, eng_valid_o, eng_key_o, data_o, valid_o, err_o
  );

  modport master (
    output data_i, valid_i, sel_i, key_i, eng_busy_i, eng_data_i, eng_valid_i,
    input  busy_o, eng_data_o, eng_valid_o, eng_key_o, data_o, valid_o, err_o
  );
endinterface

// File: rtl/decryption_dispatcher.sv
// Sequencer in front of the caesar (0), scytale (1) and zigzag (2) engines.
// Latches engine select and key on the first character of a message, forwards
// the characters and the start-decryption token to the chosen engine, waits
// for that engine to go busy, then passes its output stream back through one
// registered port until the engine drains.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous, active-low reset
//   bus    - decryption_dispatcher_if.slave (upstream, engine and output signals)
module decryption_dispatcher #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 16,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 BUSY_TIMEOUT           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  decryption_dispatcher_if.slave   bus
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ROUTE,
    DISCARD,
    WAIT_BUSY,
    DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic [D_WIDTH-1:0]   eng_data_q, eng_data_d;
  logic [2:0]           eng_valid_q, eng_valid_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 in_valid;
  logic                 is_token;
  logic                 sel_busy;
  logic                 sel_valid;
  logic [D_WIDTH-1:0]   sel_data;
  logic [TW-1:0]        timer_inc;

  // Input is ignored entirely while the dispatcher reports busy.
  assign in_valid  = bus.valid_i && !busy_q;
  assign is_token  = (bus.data_i == START_DECRYPTION_TOKEN);
  assign timer_inc = timer_q + 1'b1;

  // Pick out only the selected engine's status; the others never matter.
  always_comb begin
    sel_busy  = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    case (sel_q)
      2'd0: begin
        sel_busy  = bus.eng_busy_i[0];
        sel_valid = bus.eng_valid_i[0];
        sel_data  = bus.eng_data_i[0*D_WIDTH +: D_WIDTH];
      end
      2'd1: begin
        sel_busy  = bus.eng_busy_i[1];
        sel_valid = bus.eng_valid_i[1];
        sel_data  = bus.eng_data_i[1*D_WIDTH +: D_WIDTH];
      end
      2'd2: begin
        sel_busy  = bus.eng_busy_i[2];
        sel_valid = bus.eng_valid_i[2];
        sel_data  = bus.eng_data_i[2*D_WIDTH +: D_WIDTH];
      end
      default: ;
    endcase
  end

  // Next-state logic; forwarded valids and output pulses default to zero
  // every cycle so nothing lingers past the cycle it belongs to.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    key_d       = key_q;
    count_d     = count_q;
    timer_d     = timer_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    eng_data_d  = '0;
    eng_valid_d = 3'b000;
    data_d      = '0;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // A bare token is an empty message and is silently absorbed.
        if (in_valid && !is_token) begin
          sel_d = bus.sel_i;
          key_d = bus.key_i;
          ovf_d = 1'b0;
          if (bus.sel_i != 2'd3) begin
            eng_data_d  = bus.data_i;
            eng_valid_d = 3'b001 << bus.sel_i;
            count_d     = CW'(1);
            state_d     = ROUTE;
          end else begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end
      end

      ROUTE: begin
        if (in_valid) begin
          if (is_token) begin
            eng_data_d  = bus.data_i;
            eng_valid_d = 3'b001 << sel_q;
            err_d       = ovf_q;
            busy_d      = 1'b1;
            timer_d     = '0;
            state_d     = WAIT_BUSY;
          end else if (count_q == CW'(MAX_NOF_CHARS)) begin
            ovf_d = 1'b1;
          end else begin
            eng_data_d  = bus.data_i;
            eng_valid_d = 3'b001 << sel_q;
            count_d     = count_q + 1'b1;
          end
        end
      end

      DISCARD: begin
        if (in_valid && is_token) begin
          state_d = IDLE;
        end
      end

      // The first cycle here is the token forward cycle, with timer at 0.
      WAIT_BUSY: begin
        if (sel_busy) begin
          state_d = DRAIN;
        end else if (timer_inc == TW'(BUSY_TIMEOUT)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      // Samples from the cycle busy falls are still passed through.
      DRAIN: begin
        valid_d = sel_valid;
        data_d  = sel_valid ? sel_data : '0;
        if (!sel_busy) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      key_q       <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_data_q  <= '0;
      eng_valid_q <= 3'b000;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      key_q       <= key_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      eng_data_q  <= eng_data_d;
      eng_valid_q <= eng_valid_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.eng_data_o  = eng_data_q;
  assign bus.eng_valid_o = eng_valid_q;
  assign bus.eng_key_o   = key_q;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Self-checking bench for decryption_dispatcher.
// Expected engine forwards and expected decrypted characters are queued as
// stimulus is driven and compared in order each cycle as the DUT emits them.
module tb_decryption_dispatcher;

  localparam int         D_WIDTH       = 8;
  localparam int         KEY_WIDTH     = 16;
  localparam int         MAX_NOF_CHARS = 50;
  localparam int         BUSY_TIMEOUT  = 4;
  localparam logic [7:0] TOKEN         = 8'hFA;

  typedef struct packed {
    logic [1:0] eng;
    logic [7:0] ch;
  } fwd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fwd_t       fwd_q[$];
  logic [7:0] out_q[$];
  int         total = 0;
  int         bad = 0;
  int         err_seen = 0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  decryption_dispatcher_if #(.D_WIDTH(D_WIDTH), .KEY_WIDTH(KEY_WIDTH)) bus ();

  decryption_dispatcher #(
    .D_WIDTH(D_WIDTH),
    .KEY_WIDTH(KEY_WIDTH),
    .MAX_NOF_CHARS(MAX_NOF_CHARS),
    .START_DECRYPTION_TOKEN(TOKEN),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // One clock cycle: score the current cycle's outputs at the falling edge,
  // then return just after the next rising edge.
  task automatic step();
    fwd_t       ef;
    logic [7:0] ec;
    @(negedge clk);
    if (mon_en) begin
      if (bus.eng_valid_o !== 3'b000) begin
        total++;
        if (fwd_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL fwd_unexpected: got eng_valid_o=%b eng_data_o=%h, want no forward",
                   bus.eng_valid_o, bus.eng_data_o);
        end else begin
          ef = fwd_q.pop_front();
          if (bus.eng_valid_o !== (3'b001 << ef.eng) || bus.eng_data_o !== ef.ch) begin
            bad++;
            $display("[TB] FAIL fwd_data: got eng_valid_o=%b eng_data_o=%h, want %b %h",
                     bus.eng_valid_o, bus.eng_data_o, 3'b001 << ef.eng, ef.ch);
          end
        end
      end
      if (bus.valid_o !== 1'b0) begin
        total++;
        if (out_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL out_unexpected: got valid_o=%b data_o=%h, want no output",
                   bus.valid_o, bus.data_o);
        end else begin
          ec = out_q.pop_front();
          if (bus.data_o !== ec) begin
            bad++;
            $display("[TB] FAIL out_data: got data_o=%h, want %h", bus.data_o, ec);
          end
        end
      end
      if (bus.err_o === 1'b1) err_seen++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input logic [1:0] s, input logic [15:0] k);
    bus.valid_i = 1'b1;
    bus.data_i  = c;
    bus.sel_i   = s;
    bus.key_i   = k;
    step();
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.sel_i   = '0;
    bus.key_i   = '0;
  endtask

  task automatic expect_fwd(input logic [1:0] e, input logic [7:0] c);
    fwd_t f;
    f.eng = e;
    f.ch  = c;
    fwd_q.push_back(f);
  endtask

  // Sends n characters starting at base, then the token. Only the first
  // MAX_NOF_CHARS characters and the token reach a valid engine.
  task automatic send_msg(input logic [1:0] s, input logic [15:0] k, input int n,
                          input logic [7:0] base);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = base + 8'(i);
      if (s != 2'd3 && i < MAX_NOF_CHARS) expect_fwd(s, c);
      send_char(c, s, k);
    end
    if (s != 2'd3) expect_fwd(s, TOKEN);
    send_char(TOKEN, s, k);
  endtask

  // Engine model started at the token forward cycle: raises busy after
  // 'delay' cycles, emits n characters, drops busy with the last one.
  // A noise engine (>=0) is busy and valid throughout with junk data.
  task automatic engine_run(input int e, input int delay, input int n,
                            input logic [7:0] base, input int noise_e);
    if (noise_e >= 0) bus.eng_busy_i[noise_e] = 1'b1;
    repeat (delay) step();
    bus.eng_busy_i[e] = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      bus.eng_valid_i = 3'b000;
      bus.eng_valid_i[e] = 1'b1;
      bus.eng_data_i[e*8 +: 8] = base + 8'(i);
      if (noise_e >= 0) begin
        bus.eng_valid_i[noise_e] = 1'b1;
        bus.eng_data_i[noise_e*8 +: 8] = 8'h55;
      end
      out_q.push_back(base + 8'(i));
      if (i == n - 1) bus.eng_busy_i[e] = 1'b0;
      step();
    end
    bus.eng_valid_i = 3'b000;
    bus.eng_busy_i  = 3'b000;
    bus.eng_data_i  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h41;
    step();
    step();
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    rst_n = 1'b1;
    total++;
    if ({bus.busy_o, bus.eng_valid_o, bus.eng_data_o, bus.eng_key_o,
         bus.data_o, bus.valid_o, bus.err_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got busy=%b eng_valid=%b eng_data=%h key=%h data=%h valid=%b err=%b, want all 0",
               bus.busy_o, bus.eng_valid_o, bus.eng_data_o, bus.eng_key_o,
               bus.data_o, bus.valid_o, bus.err_o);
    end
    mon_en = 1'b1;
  endtask

  task automatic check_drained(input string name);
    repeat (2) step();
    total++;
    if (fwd_q.size() != 0 || out_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_queues: got pending fwd=%0d out=%0d, want 0 0",
               name, fwd_q.size(), out_q.size());
    end
    total++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 8'h00) begin
      bad++;
      $display("[TB] FAIL %s_idle: got busy=%b valid=%b data=%h, want 0 0 00",
               name, bus.busy_o, bus.valid_o, bus.data_o);
    end
  endtask

  task automatic test_caesar();
    int e0 = err_seen;
    expect_fwd(2'd0, 8'h41);
    send_char(8'h41, 2'd0, 16'd3);
    expect_fwd(2'd0, 8'h42);
    send_char(8'h42, 2'd0, 16'd0);
    expect_fwd(2'd0, 8'h43);
    send_char(8'h43, 2'd0, 16'd0);
    expect_fwd(2'd0, TOKEN);
    send_char(TOKEN, 2'd0, 16'd0);
    total++;
    if (bus.busy_o !== 1'b1 || bus.eng_key_o !== 16'd3) begin
      bad++;
      $display("[TB] FAIL caesar_busy_key: got busy=%b key=%h, want 1 0003", bus.busy_o, bus.eng_key_o);
    end
    engine_run(0, 2, 3, 8'h78, -1);
    total++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL caesar_fall: got busy=%b valid=%b, want 0 1", bus.busy_o, bus.valid_o);
    end
    check_drained("caesar");
    total++;
    if (err_seen != e0) begin
      bad++;
      $display("[TB] FAIL caesar_err: got %0d err pulses, want 0", err_seen - e0);
    end
  endtask

  task automatic test_zigzag_noise();
    int e0 = err_seen;
    send_msg(2'd2, 16'h0005, 5, 8'h30);
    engine_run(2, 2, 4, 8'h90, 1);
    check_drained("zigzag");
    total++;
    if (err_seen != e0) begin
      bad++;
      $display("[TB] FAIL zigzag_err: got %0d err pulses, want 0", err_seen - e0);
    end
  endtask

  task automatic test_bad_select();
    int e0 = err_seen;
    send_char(8'h61, 2'd3, 16'h00AA);
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL badsel_err_first: got err_o=%b, want 1", bus.err_o);
    end
    send_msg(2'd3, 16'h00AA, 3, 8'h62);
    total++;
    if (err_seen != e0 + 1) begin
      bad++;
      $display("[TB] FAIL badsel_err_count: got %0d err pulses, want 1", err_seen - e0);
    end
    send_msg(2'd1, 16'h0102, 3, 8'h50);
    total++;
    if (bus.eng_key_o !== 16'h0102) begin
      bad++;
      $display("[TB] FAIL badsel_next_key: got key=%h, want 0102", bus.eng_key_o);
    end
    engine_run(1, 1, 2, 8'hA0, -1);
    check_drained("badsel_next");
  endtask

  task automatic test_overflow();
    send_msg(2'd0, 16'h1234, MAX_NOF_CHARS + 2, 8'h20);
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_err_token: got err_o=%b, want 1", bus.err_o);
    end
    engine_run(0, 1, 2, 8'h61, -1);
    check_drained("ovf");
  endtask

  task automatic test_timeout();
    send_msg(2'd2, 16'h0007, 2, 8'h44);
    for (int i = 0; i <= BUSY_TIMEOUT; i++) begin
      total++;
      if (bus.err_o !== (i == BUSY_TIMEOUT) || bus.busy_o !== (i != BUSY_TIMEOUT)) begin
        bad++;
        $display("[TB] FAIL timeout_cycle%0d: got err=%b busy=%b, want %b %b",
                 i, bus.err_o, bus.busy_o, i == BUSY_TIMEOUT, i != BUSY_TIMEOUT);
      end
      step();
    end
    check_drained("timeout");
  endtask

  task automatic test_reset_mid();
    int e0;
    expect_fwd(2'd0, 8'h41);
    send_char(8'h41, 2'd0, 16'h0007);
    expect_fwd(2'd0, 8'h42);
    send_char(8'h42, 2'd0, 16'h0007);
    rst_n = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h43;
    step();
    rst_n = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    total++;
    if ({bus.busy_o, bus.eng_valid_o, bus.eng_data_o, bus.eng_key_o,
         bus.data_o, bus.valid_o, bus.err_o} !== '0) begin
      bad++;
      $display("[TB] FAIL rst_route_outputs: got busy=%b eng_valid=%b key=%h err=%b, want all 0",
               bus.busy_o, bus.eng_valid_o, bus.eng_key_o, bus.err_o);
    end
    e0 = err_seen;
    send_char(TOKEN, 2'd0, 16'h0000);
    step();
    total++;
    if (err_seen != e0 || fwd_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rst_bare_token: got err pulses=%0d pending fwd=%0d, want 0 0",
               err_seen - e0, fwd_q.size());
    end

    send_msg(2'd1, 16'h0033, 1, 8'h58);
    bus.eng_busy_i[1] = 1'b1;
    step();
    bus.eng_valid_i[1] = 1'b1;
    bus.eng_data_i[15:8] = 8'h71;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.eng_valid_i = 3'b000;
    bus.eng_busy_i  = 3'b000;
    bus.eng_data_i  = '0;
    total++;
    if ({bus.busy_o, bus.eng_valid_o, bus.eng_data_o, bus.eng_key_o,
         bus.data_o, bus.valid_o, bus.err_o} !== '0) begin
      bad++;
      $display("[TB] FAIL rst_drain_outputs: got busy=%b valid=%b data=%h key=%h, want all 0",
               bus.busy_o, bus.valid_o, bus.data_o, bus.eng_key_o);
    end
    e0 = err_seen;
    send_char(TOKEN, 2'd1, 16'h0000);
    check_drained("rst_drain");
    total++;
    if (err_seen != e0) begin
      bad++;
      $display("[TB] FAIL rst_drain_token_err: got %0d err pulses, want 0", err_seen - e0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.data_i      = '0;
    bus.valid_i     = 1'b0;
    bus.sel_i       = '0;
    bus.key_i       = '0;
    bus.eng_busy_i  = 3'b000;
    bus.eng_data_i  = '0;
    bus.eng_valid_i = 3'b000;
    @(posedge clk);
    #1;
    test_reset();
    test_caesar();
    test_zigzag_noise();
    test_bad_select();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
